hidden_forward: RTL and testbench

HIDDEN_FORWARD -- requirements
Module: hidden_forward

---
 rtl/hidden_forward.sv | 145 ++++++++++++++
 tb/tb_hidden_forward.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hidden_forward.sv
// Single-neuron forward pass: 4 binary inputs with signed weights are accumulated,
// passed through ReLU, then multiplied by an unsigned output weight using shift-add.
module hidden_forward (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        zero_weight_reset_i,
  input  logic [3:0]  x_i,
  input  logic [7:0]  w0_i,
  input  logic [7:0]  w1_i,
  input  logic [7:0]  w2_i,
  input  logic [7:0]  w3_i,
  input  logic [7:0]  v_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [9:0]  hidden_val_o,
  output logic [18:0] final_o
);

  // state | meaning
  // IDLE  | waiting for start_i, operands captured on acceptance
  // ACC   | one weighted input accumulated per cycle, idx 0..3
  // ACT   | ReLU on the accumulator, product cleared
  // MUL   | one multiplier bit per cycle, LSB first, outputs loaded on bit 7
  // DONE  | result strobe for exactly one cycle
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC  = 3'd1;
  localparam logic [2:0] S_ACT  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [3:0]       x_q, x_d;
  logic [3:0][7:0]  w_q, w_d;
  logic [7:0]       v_q, v_d;
  logic [9:0]       acc_q, acc_d;
  logic [1:0]       idx_q, idx_d;
  logic [9:0]       hid_q, hid_d;
  logic [18:0]      prod_q, prod_d;
  logic [2:0]       bit_q, bit_d;
  logic [9:0]       hidden_val_q, hidden_val_d;
  logic [18:0]      final_q, final_d;

  logic [7:0]       w_sel;
  logic [18:0]      addend;

  assign w_sel  = w_q[idx_q];
  assign addend = v_q[bit_q] ? ({9'd0, hid_q} << bit_q) : 19'd0;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    w_d          = w_q;
    v_d          = v_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    hid_d        = hid_q;
    prod_d       = prod_q;
    bit_d        = bit_q;
    hidden_val_d = hidden_val_q;
    final_d      = final_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          w_d     = {w3_i, w2_i, w1_i, w0_i};
          v_d     = v_i;
          acc_d   = 10'd0;
          idx_d   = 2'd0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        // Sum of four 8-bit signed weights always fits in 10 bits signed.
        if (x_q[idx_q]) acc_d = acc_q + {{2{w_sel[7]}}, w_sel};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_ACT;
      end
      S_ACT: begin
        hid_d   = acc_q[9] ? 10'd0 : acc_q;
        prod_d  = 19'd0;
        bit_d   = 3'd0;
        state_d = S_MUL;
      end
      S_MUL: begin
        prod_d = prod_q + addend;
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          hidden_val_d = hid_q;
          final_d      = prod_q + addend;
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Synchronous clear wins over everything, including a start request.
    if (zero_weight_reset_i) begin
      state_d      = S_IDLE;
      acc_d        = 10'd0;
      idx_d        = 2'd0;
      hid_d        = 10'd0;
      prod_d       = 19'd0;
      bit_d        = 3'd0;
      hidden_val_d = 10'd0;
      final_d      = 19'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      w_q          <= '0;
      v_q          <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      hid_q        <= '0;
      prod_q       <= '0;
      bit_q        <= '0;
      hidden_val_q <= '0;
      final_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      w_q          <= w_d;
      v_q          <= v_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      hid_q        <= hid_d;
      prod_q       <= prod_d;
      bit_q        <= bit_d;
      hidden_val_q <= hidden_val_d;
      final_q      <= final_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign valid_o      = (state_q == S_DONE);
  assign hidden_val_o = hidden_val_q;
  assign final_o      = final_q;

endmodule

// File: tb/tb_hidden_forward.sv
// Bench for hidden_forward: directed and random passes against an arithmetic model
// of the neuron, plus timing, start-ignore, clear and reset behaviour.
module tb_hidden_forward;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        zero_weight_reset_i;
  logic [3:0]  x_i;
  logic [7:0]  w0_i, w1_i, w2_i, w3_i, v_i;
  logic        busy_o;
  logic        valid_o;
  logic [9:0]  hidden_val_o;
  logic [18:0] final_o;

  int checks = 0;
  int errors = 0;

  hidden_forward dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .start_i             (start_i),
    .zero_weight_reset_i (zero_weight_reset_i),
    .x_i                 (x_i),
    .w0_i                (w0_i),
    .w1_i                (w1_i),
    .w2_i                (w2_i),
    .w3_i                (w3_i),
    .v_i                 (v_i),
    .busy_o              (busy_o),
    .valid_o             (valid_o),
    .hidden_val_o        (hidden_val_o),
    .final_o             (final_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    x_i  = 4'($urandom);
    w0_i = 8'($urandom);
    w1_i = 8'($urandom);
    w2_i = 8'($urandom);
    w3_i = 8'($urandom);
    v_i  = 8'($urandom);
  endtask

  // Drive a start at the current negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [3:0] x, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input logic [7:0] v);
    x_i = x; w0_i = a; w1_i = b; w2_i = c; w3_i = d; v_i = v;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic run_pass(input string tag, input logic [3:0] x, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                          input logic [7:0] v);
    int acc, hid, fin, cyc;
    logic [7:0] w [4];
    w = '{a, b, c, d};
    acc = 0;
    for (int i = 0; i < 4; i++)
      if (x[i]) acc += int'($signed(w[i]));
    hid = (acc < 0) ? 0 : acc;
    fin = hid * int'(v);

    launch(x, a, b, c, d, v);
    check({tag, " busy"}, 32'(busy_o), 32'd1);
    cyc = 0;
    // Operands and start are scrambled mid-pass; the DUT must ignore them.
    while (valid_o !== 1'b1 && cyc < 40) begin
      scramble_inputs();
      start_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd13);
    check({tag, " hidden"}, 32'(hidden_val_o), 32'(hid));
    check({tag, " final"}, 32'(final_o), 32'(fin));
    // A start presented at the DONE edge must not be accepted.
    scramble_inputs();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check({tag, " valid one cycle"}, 32'(valid_o), 32'd0);
    check({tag, " idle after done"}, 32'(busy_o), 32'd0);
    check({tag, " final held"}, 32'(final_o), 32'(fin));
  endtask

  initial begin
    int seen;
    rst_i = 1'b0;
    start_i = 1'b0;
    zero_weight_reset_i = 1'b0;
    x_i = '0; w0_i = '0; w1_i = '0; w2_i = '0; w3_i = '0; v_i = '0;

    #2;
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset hidden", 32'(hidden_val_o), 32'd0);
    check("reset final", 32'(final_o), 32'd0);

    // Start on the very first edge after reset release.
    @(negedge clk_i);
    rst_i = 1'b1;
    run_pass("basic", 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 8'd3);
    check("basic exact hidden", 32'(hidden_val_o), 32'd100);
    check("basic exact final", 32'(final_o), 32'd300);

    // Back-to-back: this start lands on edge N+15 of the previous pass.
    run_pass("negative", 4'b0101, 8'hFB, 8'h7F, 8'h02, 8'h7F, 8'd200);
    run_pass("max", 4'b1111, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFF);
    check("max exact final", 32'(final_o), 32'd129540);
    run_pass("zero x", 4'b0000, 8'h55, 8'h33, 8'h11, 8'h22, 8'h99);
    run_pass("min acc", 4'b1111, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFF);

    for (int i = 0; i < 20; i++)
      run_pass($sformatf("rand%0d", i), 4'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom));

    // Asynchronous reset while in MUL.
    run_pass("pre reset", 4'b1111, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFF);
    launch(4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 8'd3);
    repeat (7) @(negedge clk_i);
    check("pre reset in mul", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("mid reset busy", 32'(busy_o), 32'd0);
    check("mid reset valid", 32'(valid_o), 32'd0);
    check("mid reset hidden", 32'(hidden_val_o), 32'd0);
    check("mid reset final", 32'(final_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (valid_o === 1'b1 || busy_o === 1'b1) seen++;
    end
    check("aborted pass silent", 32'(seen), 32'd0);

    // Synchronous clear at N+2 together with start.
    run_pass("pre clear", 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 8'd3);
    launch(4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 8'd3);
    @(negedge clk_i);
    zero_weight_reset_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    zero_weight_reset_i = 1'b0;
    start_i = 1'b0;
    check("clear busy", 32'(busy_o), 32'd0);
    check("clear valid", 32'(valid_o), 32'd0);
    check("clear hidden", 32'(hidden_val_o), 32'd0);
    check("clear final", 32'(final_o), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (valid_o === 1'b1 || busy_o === 1'b1) seen++;
    end
    check("clear no new pass", 32'(seen), 32'd0);
    run_pass("after clear", 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
